// File: rtl/four_req_rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Owners are preempted after MAX_HOLD cycles, but only while someone else is waiting.
module four_req_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       any_req,
   output logic       preempt
);

   typedef enum logic {StIdle, StOwn} state_e;

   localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

   state_e     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] hold_q, hold_d;
   logic       preempt_q, preempt_d;

   logic [1:0] pick;
   logic [3:0] owner_onehot;
   logic       others;

   assign any_req      = |req;
   assign owner_onehot = 4'b0001 << owner_q;
   assign others       = |(req & ~owner_onehot);

   // Scan from the farthest offset down so the nearest requester to ptr wins.
   always_comb begin
      pick = ptr_q;
      if (req[ptr_q + 2'd3]) pick = ptr_q + 2'd3;
      if (req[ptr_q + 2'd2]) pick = ptr_q + 2'd2;
      if (req[ptr_q + 2'd1]) pick = ptr_q + 2'd1;
      if (req[ptr_q])        pick = ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         owner_q   <= 2'd0;
         ptr_q     <= 2'd0;
         hold_q    <= 4'd0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d = StOwn;
               owner_d = pick;
               hold_d  = 4'd1;
            end
         end
         StOwn: begin
            // A voluntary release takes precedence over expiry in the same cycle.
            if (!req[owner_q]) begin
               state_d = StIdle;
               ptr_d   = owner_q + 2'd1;
               hold_d  = 4'd0;
            end else if ((hold_q == MaxHold) && others) begin
               state_d   = StIdle;
               ptr_d     = owner_q + 2'd1;
               hold_d    = 4'd0;
               preempt_d = 1'b1;
            end else if (hold_q != MaxHold) begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      grant    = 4'b0000;
      grant_id = 2'd0;
      busy     = 1'b0;
      preempt  = preempt_q;
      if (state_q == StOwn) begin
         grant    = owner_onehot;
         grant_id = owner_q;
         busy     = 1'b1;
      end
   end

endmodule

// File: tb/tb_four_req_rr_arbiter.sv
// Bench for four_req_rr_arbiter with MAX_HOLD=4: vector table plus an async-reset sequence.
module tb_four_req_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       any_req;
   logic       preempt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] grant;
      logic       pre;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   four_req_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .any_req  (any_req),
      .preempt  (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [1:0] id_of(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic void add(input logic rst, input logic [3:0] r, input logic [3:0] g,
                               input logic p, input int n);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.rst   = (k == 0) ? rst : 1'b0;
         v.req   = r;
         v.grant = g;
         v.pre   = p;
         vecs.push_back(v);
      end
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " grant"}, grant, 4'b0000);
      chk({tag, " grant_id"}, {2'b00, grant_id}, 4'd0);
      chk({tag, " busy"}, {3'b000, busy}, 4'd0);
      chk({tag, " preempt"}, {3'b000, preempt}, 4'd0);
      chk({tag, " any_req"}, {3'b000, any_req}, {3'b000, |req});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      #1;
      n_vec++;
      chk_idle_outputs("reset");
      #2 rst_n = 1'b1;
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk);
      req = v.req;
      exp_q.push_back(v);
      #1 chk("any_req", {3'b000, any_req}, {3'b000, |v.req});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      chk("grant", grant, e.grant);
      chk("grant_id", {2'b00, grant_id}, {2'b00, id_of(e.grant)});
      chk("busy", {3'b000, busy}, {3'b000, |e.grant});
      chk("preempt", {3'b000, preempt}, {3'b000, e.pre});
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0;
      req   = 4'b0000;

      // Grant latency and one dead cycle on handover.
      add(1, 4'b0101, 4'b0001, 0, 1);
      add(0, 4'b0100, 4'b0000, 0, 1);
      add(0, 4'b0100, 4'b0100, 0, 1);
      add(0, 4'b0000, 4'b0000, 0, 1);
      // Full rotation under continuous requests.
      add(1, 4'b1111, 4'b0001, 0, 4);
      add(0, 4'b1111, 4'b0000, 1, 1);
      add(0, 4'b1111, 4'b0010, 0, 4);
      add(0, 4'b1111, 4'b0000, 1, 1);
      add(0, 4'b1111, 4'b0100, 0, 4);
      add(0, 4'b1111, 4'b0000, 1, 1);
      add(0, 4'b1111, 4'b1000, 0, 4);
      add(0, 4'b1111, 4'b0000, 1, 1);
      add(0, 4'b1111, 4'b0001, 0, 1);
      add(0, 4'b0000, 4'b0000, 0, 1);
      // Owner 1 releases exactly at expiry: no preempt.
      add(0, 4'b0110, 4'b0010, 0, 4);
      add(0, 4'b0100, 4'b0000, 0, 1);
      add(0, 4'b0100, 4'b0100, 0, 1);
      add(0, 4'b0000, 4'b0000, 0, 1);
      // Owner 3 ignores non-owner churn, saturates alone, then is preempted.
      add(0, 4'b1000, 4'b1000, 0, 1);
      add(0, 4'b1111, 4'b1000, 0, 1);
      add(0, 4'b1010, 4'b1000, 0, 1);
      add(0, 4'b1000, 4'b1000, 0, 4);
      add(0, 4'b1001, 4'b0000, 1, 1);
      add(0, 4'b1001, 4'b0001, 0, 1);
      add(0, 4'b0000, 4'b0000, 0, 1);
      // Lone requester held 20 cycles.
      add(0, 4'b0100, 4'b0100, 0, 20);
      add(0, 4'b0000, 4'b0000, 0, 1);
      // Pointer at 3 wraps to 0 after release.
      add(0, 4'b1001, 4'b1000, 0, 2);
      add(0, 4'b0001, 4'b0000, 0, 1);
      add(0, 4'b0001, 4'b0001, 0, 1);
      add(0, 4'b0000, 4'b0000, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         apply(vecs[i]);
      end

      // Asynchronous reset while owner 1 holds the grant (ptr is 1 here).
      v.rst = 1'b0; v.req = 4'b0010; v.grant = 4'b0010; v.pre = 1'b0;
      apply(v);
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      chk_idle_outputs("async_reset");
      req = 4'b0110;
      #1 chk("any_req_in_reset", {3'b000, any_req}, 4'd1);
      rst_n = 1'b1;
      req   = 4'b0000;
      v.req = 4'b0000; v.grant = 4'b0000;
      apply(v);
      v.req = 4'b1111; v.grant = 4'b0001;
      apply(v);
      v.req = 4'b0000; v.grant = 4'b0000;
      apply(v);

      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
